dual_down_counter: RTL

DUAL_DOWN_COUNTER -- requirements
Module: dual_down_counter

---
 rtl/dual_down_counter_if.sv | 24 ++
 rtl/dual_down_counter.sv | 94 +++++++++
 2 files changed

// File: rtl/dual_down_counter_if.sv
// Control and status bundle for dual_down_counter: channel select, load/ack/enable
// strobes and preset value in, per-channel counts and expiry flags out.
interface dual_down_counter_if;
  logic        Slt;
  logic        En;
  logic        Load;
  logic        Ack;
  logic [63:0] Din;
  logic [63:0] Output0;
  logic [63:0] Output1;
  logic        Zero0;
  logic        Zero1;
  logic        Irq;

  modport master (
    output Slt, En, Load, Ack, Din,
    input  Output0, Output1, Zero0, Zero1, Irq
  );

  modport slave (
    input  Slt, En, Load, Ack, Din,
    output Output0, Output1, Zero0, Zero1, Irq
  );
endinterface

// File: rtl/dual_down_counter.sv
// Two 64-bit down counters sharing one command port; channel 1 counts once per
// four enabled cycles through a 2-bit prescaler. Expiry raises Zero0/Zero1 and Irq.
module dual_down_counter (
  input  logic              Clk,
  input  logic              Reset,
  dual_down_counter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  logic [1:0][63:0] count_all;
  logic [1:0]       zero_all;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    localparam logic CH = 1'(gi);

    state_e      state_q, state_d;
    logic [63:0] count_q, count_d;
    logic        sel;
    logic        tick;

    assign sel = (bus.Slt == CH);

    // Decrements only when the channel's prescaler allows it (always for channel 0).
    always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (sel && bus.Load) begin
        count_d = bus.Din;
        state_d = (bus.Din == 64'd0) ? ST_EXPIRED : ST_RUN;
      end else if (sel && bus.Ack) begin
        if (state_q == ST_EXPIRED) begin
          state_d = ST_IDLE;
        end
      end else if (sel && bus.En && (state_q == ST_RUN) && tick) begin
        count_d = count_q - 64'd1;
        if (count_q == 64'd1) begin
          state_d = ST_EXPIRED;
        end
      end
    end

    always_ff @(posedge Clk) begin
      if (Reset) begin
        state_q <= ST_IDLE;
        count_q <= 64'd0;
      end else begin
        state_q <= state_d;
        count_q <= count_d;
      end
    end

    if (gi == 1) begin : g_presc
      logic [1:0] presc_q, presc_d;

      // The wrap from 3 to 0 is the decrement cycle, which also leaves the
      // prescaler at 0 when the channel expires.
      always_comb begin
        presc_d = presc_q;
        if (sel && bus.Load) begin
          presc_d = 2'd0;
        end else if (sel && !bus.Ack && bus.En && (state_q == ST_RUN)) begin
          presc_d = presc_q + 2'd1;
        end
      end

      always_ff @(posedge Clk) begin
        if (Reset) begin
          presc_q <= 2'd0;
        end else begin
          presc_q <= presc_d;
        end
      end

      assign tick = (presc_q == 2'd3);
    end else begin : g_nopresc
      assign tick = 1'b1;
    end

    assign count_all[gi] = count_q;
    assign zero_all[gi]  = (state_q == ST_EXPIRED);
  end

  assign bus.Output0 = count_all[0];
  assign bus.Output1 = count_all[1];
  assign bus.Zero0   = zero_all[0];
  assign bus.Zero1   = zero_all[1];
  assign bus.Irq     = |zero_all;

endmodule
